// File: rtl/regfile_mp_pkg.sv
// Shared register-file constants and the architectural address/data types.
// Pure types; no logic, no latency, no backpressure.
package regfile_mp_pkg;

    localparam int XLEN_DEF   = 32;
    localparam int NREGS_DEF  = 32;
    localparam int ADDR_W_DEF = $clog2(NREGS_DEF);

    typedef logic [ADDR_W_DEF-1:0] reg_addr_t;
    typedef logic [XLEN_DEF-1:0]   reg_data_t;

endpackage

// File: rtl/rf_read_port.sv
// One read port: storage select, x0 gate, optional write bypass and busy lookup.
// Latency: combinational; backpressure: none (always answers).
module rf_read_port
    import regfile_mp_pkg::*;
#(
    parameter int XLEN   = XLEN_DEF,
    parameter int NREGS  = NREGS_DEF,
    parameter int NWR    = 2,
    parameter int BYPASS = 1,
    localparam int ADDR_W = $clog2(NREGS)
)(
    input  logic [NREGS-1:0][XLEN-1:0]   regs,
    input  logic [NREGS-1:0]             busy,
    input  logic [NWR-1:0]               we,
    input  logic [NWR-1:0][ADDR_W-1:0]   wdest,
    input  logic [NWR-1:0][XLEN-1:0]     wdata,
    input  logic [ADDR_W-1:0]            raddr,
    output logic [XLEN-1:0]              rdata,
    output logic                         rbusy
);

    always_comb begin
        rdata = '0;
        rbusy = 1'b0;
        if (raddr != '0) begin
            rdata = regs[raddr];
            rbusy = busy[raddr];
            // Ascending scan so the highest-numbered matching write port wins.
            if (BYPASS != 0) begin
                for (int p = 0; p < NWR; p++) begin
                    if (we[p] && (wdest[p] == raddr)) begin
                        rdata = wdata[p];
                        rbusy = 1'b0;
                    end
                end
            end
        end
    end

endmodule

// File: rtl/regfile_mp.sv
// Multi-ported register file with per-register busy scoreboard for issue tracking.
// Latency: writes/allocs visible next edge (same cycle with bypass); backpressure: alloc_ready drops on WAW.
module regfile_mp
    import regfile_mp_pkg::*;
#(
    parameter int XLEN   = XLEN_DEF,
    parameter int NREGS  = NREGS_DEF,
    parameter int NRD    = 4,
    parameter int NWR    = 2,
    parameter int BYPASS = 1,
    localparam int ADDR_W = $clog2(NREGS)
)(
    input  logic                         clk,
    input  logic                         rst,
    input  logic [NWR-1:0]               we,
    input  logic [NWR-1:0][ADDR_W-1:0]   wdest,
    input  logic [NWR-1:0][XLEN-1:0]     wdata,
    input  logic [NRD-1:0][ADDR_W-1:0]   raddr,
    output logic [NRD-1:0][XLEN-1:0]     rdata,
    output logic [NRD-1:0]               rbusy,
    input  logic                         alloc_valid,
    input  logic [ADDR_W-1:0]            alloc_dest,
    output logic                         alloc_ready
);

    // x0 has no storage; the views splice in a constant zero entry.
    logic [NREGS-1:1][XLEN-1:0] mem_q, mem_d;
    logic [NREGS-1:1]           busy_q, busy_d;
    logic [NREGS-1:0][XLEN-1:0] mem_view;
    logic [NREGS-1:0]           busy_view;
    logic                       alloc_wr_hit;
    logic                       alloc_fire;

    assign mem_view  = {mem_q, {XLEN{1'b0}}};
    assign busy_view = {busy_q, 1'b0};

    always_comb begin
        alloc_wr_hit = 1'b0;
        for (int p = 0; p < NWR; p++) begin
            if (we[p] && (wdest[p] == alloc_dest)) begin
                alloc_wr_hit = 1'b1;
            end
        end
    end

    // Independent of alloc_valid so upstream may gate valid on ready.
    assign alloc_ready = (alloc_dest == '0) || !busy_view[alloc_dest] || alloc_wr_hit;
    assign alloc_fire  = alloc_valid && alloc_ready;

    always_comb begin
        mem_d  = mem_q;
        busy_d = busy_q;
        for (int p = 0; p < NWR; p++) begin
            if (we[p] && (wdest[p] != '0)) begin
                mem_d[wdest[p]]  = wdata[p];
                busy_d[wdest[p]] = 1'b0;
            end
        end
        // A new producer issued alongside the old one's writeback keeps the register busy.
        if (alloc_fire && (alloc_dest != '0)) begin
            busy_d[alloc_dest] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mem_q  <= '0;
            busy_q <= '0;
        end else begin
            mem_q  <= mem_d;
            busy_q <= busy_d;
        end
    end

    generate
        for (genvar r = 0; r < NRD; r++) begin : g_rd
            rf_read_port #(
                .XLEN   (XLEN),
                .NREGS  (NREGS),
                .NWR    (NWR),
                .BYPASS (BYPASS)
            ) u_rd (
                .regs   (mem_view),
                .busy   (busy_view),
                .we     (we),
                .wdest  (wdest),
                .wdata  (wdata),
                .raddr  (raddr[r]),
                .rdata  (rdata[r]),
                .rbusy  (rbusy[r])
            );
        end
    endgenerate

endmodule

// File: tb/tb_regfile_mp.sv
// Bench for regfile_mp: bypass and non-bypass instances share stimulus and a
// behavioural array model of register contents and busy flags.
module tb_regfile_mp;
    import regfile_mp_pkg::*;

    logic             clk = 1'b0;
    logic             rst;
    logic [1:0]       we;
    logic [1:0][4:0]  wdest;
    logic [1:0][31:0] wdata;
    logic [3:0][4:0]  raddr;
    logic             alloc_valid;
    logic [4:0]       alloc_dest;
    logic [3:0][31:0] rdata_b, rdata_n;
    logic [3:0]       rbusy_b, rbusy_n;
    logic             ready_b, ready_n;

    int n_checks = 0;
    int n_errors = 0;

    reg_data_t m_regs [32];
    logic      m_busy [32];

    always #5 clk = ~clk;

    regfile_mp #(.BYPASS(1)) dut_b (
        .clk(clk), .rst(rst), .we(we), .wdest(wdest), .wdata(wdata),
        .raddr(raddr), .rdata(rdata_b), .rbusy(rbusy_b),
        .alloc_valid(alloc_valid), .alloc_dest(alloc_dest), .alloc_ready(ready_b)
    );

    regfile_mp #(.BYPASS(0)) dut_n (
        .clk(clk), .rst(rst), .we(we), .wdest(wdest), .wdata(wdata),
        .raddr(raddr), .rdata(rdata_n), .rbusy(rbusy_n),
        .alloc_valid(alloc_valid), .alloc_dest(alloc_dest), .alloc_ready(ready_n)
    );

    function automatic logic wr_hits(input logic [4:0] a);
        return (we[0] && wdest[0] == a) || (we[1] && wdest[1] == a);
    endfunction

    function automatic logic [31:0] exp_rdata(input logic [4:0] a, input bit byp);
        logic [31:0] v;
        if (a == 5'd0) return 32'h0;
        v = m_regs[a];
        if (byp) begin
            if (we[0] && wdest[0] == a) v = wdata[0];
            if (we[1] && wdest[1] == a) v = wdata[1];
        end
        return v;
    endfunction

    function automatic logic exp_rbusy(input logic [4:0] a, input bit byp);
        if (a == 5'd0) return 1'b0;
        if (byp && wr_hits(a)) return 1'b0;
        return m_busy[a];
    endfunction

    function automatic logic exp_ready();
        return (alloc_dest == 5'd0) || !m_busy[alloc_dest] || wr_hits(alloc_dest);
    endfunction

    task automatic model_edge();
        logic rdy;
        rdy = exp_ready();
        if (rst) begin
            for (int i = 0; i < 32; i++) begin
                m_regs[i] = '0;
                m_busy[i] = 1'b0;
            end
        end else begin
            for (int p = 0; p < 2; p++) begin
                if (we[p] && wdest[p] != 5'd0) begin
                    m_regs[wdest[p]] = wdata[p];
                    m_busy[wdest[p]] = 1'b0;
                end
            end
            if (alloc_valid && rdy && alloc_dest != 5'd0) m_busy[alloc_dest] = 1'b1;
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    task automatic idle();
        we = '0; wdest = '0; wdata = '0; raddr = '0;
        alloc_valid = 1'b0; alloc_dest = '0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle();
        cycle();
        rst = 1'b0;
        raddr = {5'd4, 5'd3, 5'd2, 5'd1};
        #1;
        for (int r = 0; r < 4; r++) begin
            n_checks++;
            if (rdata_b[r] !== 32'h0 || rdata_n[r] !== 32'h0) begin
                n_errors++;
                $display("FAIL reset_rdata[%0d] got %h/%h exp 0", r, rdata_b[r], rdata_n[r]);
            end
            n_checks++;
            if (rbusy_b[r] !== 1'b0 || rbusy_n[r] !== 1'b0) begin
                n_errors++;
                $display("FAIL reset_rbusy[%0d] got %b/%b exp 0", r, rbusy_b[r], rbusy_n[r]);
            end
        end
        n_checks++;
        if (ready_b !== 1'b1 || ready_n !== 1'b1) begin
            n_errors++;
            $display("FAIL reset_ready got %b/%b exp 1", ready_b, ready_n);
        end
    endtask

    task automatic test_port_priority();
        idle();
        we = 2'b11; wdest[0] = 5'd5; wdest[1] = 5'd5;
        wdata[1] = 32'hAAAA_0000; wdata[0] = 32'h0000_1111; raddr[0] = 5'd5;
        #1;
        n_checks++;
        if (rdata_b[0] !== 32'hAAAA_0000) begin
            n_errors++;
            $display("FAIL prio_bypass got %h exp aaaa0000", rdata_b[0]);
        end
        n_checks++;
        if (rdata_n[0] !== 32'h0) begin
            n_errors++;
            $display("FAIL prio_nobypass_old got %h exp 0", rdata_n[0]);
        end
        cycle();
        idle();
        raddr[0] = 5'd5;
        #1;
        n_checks++;
        if (rdata_b[0] !== 32'hAAAA_0000 || rdata_n[0] !== 32'hAAAA_0000) begin
            n_errors++;
            $display("FAIL prio_stored got %h/%h exp aaaa0000", rdata_b[0], rdata_n[0]);
        end
    endtask

    task automatic test_x0();
        idle();
        we = 2'b01; wdest[0] = 5'd0; wdata[0] = 32'hDEAD;
        alloc_valid = 1'b1; alloc_dest = 5'd0;
        #1;
        n_checks++;
        if (rdata_b[0] !== 32'h0) begin
            n_errors++;
            $display("FAIL x0_bypass got %h exp 0", rdata_b[0]);
        end
        n_checks++;
        if (ready_b !== 1'b1) begin
            n_errors++;
            $display("FAIL x0_ready got %b exp 1", ready_b);
        end
        cycle();
        idle();
        #1;
        n_checks++;
        if (rdata_b[0] !== 32'h0 || rdata_n[0] !== 32'h0 || rbusy_b[0] !== 1'b0) begin
            n_errors++;
            $display("FAIL x0_after got %h/%h busy %b exp 0/0/0", rdata_b[0], rdata_n[0], rbusy_b[0]);
        end
    endtask

    task automatic test_waw();
        idle();
        alloc_valid = 1'b1; alloc_dest = 5'd7;
        #1;
        n_checks++;
        if (ready_b !== 1'b1) begin
            n_errors++;
            $display("FAIL waw_first_ready got %b exp 1", ready_b);
        end
        cycle();
        idle();
        raddr[0] = 5'd7; alloc_valid = 1'b1; alloc_dest = 5'd7;
        #1;
        n_checks++;
        if (rbusy_b[0] !== 1'b1 || rbusy_n[0] !== 1'b1) begin
            n_errors++;
            $display("FAIL waw_busy got %b/%b exp 1", rbusy_b[0], rbusy_n[0]);
        end
        n_checks++;
        if (ready_b !== 1'b0 || ready_n !== 1'b0) begin
            n_errors++;
            $display("FAIL waw_stall got %b/%b exp 0", ready_b, ready_n);
        end
        we = 2'b01; wdest[0] = 5'd7; wdata[0] = 32'h42;
        #1;
        n_checks++;
        if (ready_b !== 1'b1 || ready_n !== 1'b1) begin
            n_errors++;
            $display("FAIL waw_wr_ready got %b/%b exp 1", ready_b, ready_n);
        end
        n_checks++;
        if (rbusy_b[0] !== 1'b0 || rbusy_n[0] !== 1'b1) begin
            n_errors++;
            $display("FAIL waw_wr_rbusy got %b/%b exp 0/1", rbusy_b[0], rbusy_n[0]);
        end
        cycle();
        idle();
        raddr[0] = 5'd7;
        #1;
        n_checks++;
        if (rbusy_b[0] !== 1'b1 || rdata_b[0] !== 32'h42 || rdata_n[0] !== 32'h42) begin
            n_errors++;
            $display("FAIL waw_set_wins busy %b data %h/%h exp 1 42", rbusy_b[0], rdata_b[0], rdata_n[0]);
        end
    endtask

    task automatic test_bypass_clear();
        idle();
        alloc_valid = 1'b1; alloc_dest = 5'd9;
        cycle();
        idle();
        we = 2'b10; wdest[1] = 5'd9; wdata[1] = 32'h99; raddr[0] = 5'd9;
        #1;
        n_checks++;
        if (rbusy_b[0] !== 1'b0 || rdata_b[0] !== 32'h99) begin
            n_errors++;
            $display("FAIL byp_clear busy %b data %h exp 0 99", rbusy_b[0], rdata_b[0]);
        end
        n_checks++;
        if (rbusy_n[0] !== 1'b1 || rdata_n[0] !== 32'h0) begin
            n_errors++;
            $display("FAIL nobyp_clear busy %b data %h exp 1 0", rbusy_n[0], rdata_n[0]);
        end
        cycle();
        idle();
        raddr[0] = 5'd9;
        #1;
        n_checks++;
        if (rbusy_b[0] !== 1'b0 || rbusy_n[0] !== 1'b0 || rdata_n[0] !== 32'h99) begin
            n_errors++;
            $display("FAIL clear_after busy %b/%b data %h exp 0/0 99", rbusy_b[0], rbusy_n[0], rdata_n[0]);
        end
    endtask

    task automatic test_reset_override();
        idle();
        we = 2'b01; wdest[0] = 5'd3; wdata[0] = 32'h33;
        alloc_valid = 1'b1; alloc_dest = 5'd4; rst = 1'b1;
        cycle();
        rst = 1'b0;
        idle();
        raddr = {5'd5, 5'd7, 5'd4, 5'd3}; alloc_dest = 5'd4;
        #1;
        n_checks++;
        if (rdata_b[0] !== 32'h0 || rdata_n[0] !== 32'h0 || rdata_b[3] !== 32'h0) begin
            n_errors++;
            $display("FAIL rst_ovr_data got %h/%h/%h exp 0", rdata_b[0], rdata_n[0], rdata_b[3]);
        end
        n_checks++;
        if (rbusy_b !== 4'b0 || rbusy_n !== 4'b0 || ready_b !== 1'b1) begin
            n_errors++;
            $display("FAIL rst_ovr_busy got %b/%b ready %b exp 0000 1", rbusy_b, rbusy_n, ready_b);
        end
    endtask

    function automatic logic [4:0] rand_addr();
        return ($urandom_range(0, 2) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 5));
    endfunction

    task automatic test_random();
        for (int it = 0; it < 500; it++) begin
            rst = ($urandom_range(0, 60) == 0);
            we = 2'($urandom);
            wdest[0] = rand_addr(); wdest[1] = rand_addr();
            wdata[0] = $urandom; wdata[1] = $urandom;
            for (int r = 0; r < 4; r++) raddr[r] = ($urandom_range(0, 1) == 0) ? wdest[r % 2] : rand_addr();
            alloc_valid = ($urandom_range(0, 1) == 1);
            alloc_dest = ($urandom_range(0, 3) == 0) ? wdest[0] : rand_addr();
            #1;
            for (int r = 0; r < 4; r++) begin
                n_checks++;
                if (rdata_b[r] !== exp_rdata(raddr[r], 1'b1) || rdata_n[r] !== exp_rdata(raddr[r], 1'b0)) begin
                    n_errors++;
                    $display("FAIL rand_rdata[%0d] it=%0d got %h/%h exp %h/%h", r, it,
                             rdata_b[r], rdata_n[r], exp_rdata(raddr[r], 1'b1), exp_rdata(raddr[r], 1'b0));
                end
                n_checks++;
                if (rbusy_b[r] !== exp_rbusy(raddr[r], 1'b1) || rbusy_n[r] !== exp_rbusy(raddr[r], 1'b0)) begin
                    n_errors++;
                    $display("FAIL rand_rbusy[%0d] it=%0d got %b/%b exp %b/%b", r, it,
                             rbusy_b[r], rbusy_n[r], exp_rbusy(raddr[r], 1'b1), exp_rbusy(raddr[r], 1'b0));
                end
            end
            n_checks++;
            if (ready_b !== exp_ready() || ready_n !== exp_ready()) begin
                n_errors++;
                $display("FAIL rand_ready it=%0d got %b/%b exp %b", it, ready_b, ready_n, exp_ready());
            end
            cycle();
        end
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        idle();
        for (int i = 0; i < 32; i++) begin
            m_regs[i] = '0;
            m_busy[i] = 1'b0;
        end
        @(negedge clk);
        test_reset();
        test_port_priority();
        test_x0();
        test_waw();
        test_bypass_clear();
        test_reset_override();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
